// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to 3-digit BCD converter (option macro LZ_BLANK_EN)
module bin2bcd_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   hundreds,
    output logic [3:0]   tens,
    output logic [3:0]   ones,
    output logic [2:0]   print,
    output logic         valid
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state;
    logic [W-1:0]  opnd;
    logic [11:0]   scratch;
    logic [3:0]    cnt;
    logic [11:0]   adj;
    logic [11+W:0] shifted;
    logic [11:0]   nscr;
    logic [2:0]    pr_next;
    // one double-dabble step: correct digits >= 5, then shift the combined register
    always_comb begin
        adj[3:0]   = scratch[3:0]   >= 4'd5 ? scratch[3:0]   + 4'd3 : scratch[3:0];
        adj[7:4]   = scratch[7:4]   >= 4'd5 ? scratch[7:4]   + 4'd3 : scratch[7:4];
        adj[11:8]  = scratch[11:8]  >= 4'd5 ? scratch[11:8]  + 4'd3 : scratch[11:8];
        shifted    = {adj, opnd} << 1;
        nscr       = shifted[11+W:W];
`ifdef LZ_BLANK_EN
        pr_next    = {nscr[11:8] != 4'd0, nscr[11:4] != 8'd0, 1'b1};
`else
        pr_next    = 3'b111;
`endif
    end
    // control FSM; the last shift loads the digits directly so done lands W+1 cycles after start
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opnd     <= '0;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            print    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opnd    <= bin;
                    scratch <= '0;
                    cnt     <= 4'(W);
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    opnd    <= shifted[W-1:0];
                    scratch <= nscr;
                    cnt     <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hundreds <= nscr[11:8];
                        tens     <= nscr[7:4];
                        ones     <= nscr[3:0];
                        print    <= pr_next;
                        done     <= 1'b1;
                        valid    <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning binary input width; legal range 4..8.
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  conversion request, sampled each clk.
REQ-005 SHALL have port bin  input  W  unsigned binary operand, sampled on accepted start.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when new digits are presented.
REQ-008 SHALL have port hundreds  output  4  BCD hundreds digit; feeds a 7-segment decoder hex input.
REQ-009 SHALL have port tens  output  4  BCD tens digit.
REQ-010 SHALL have port ones  output  4  BCD ones digit.
REQ-011 SHALL have port print  output  3  per-digit display enable, bit 2 = hundreds, bit 0 = ones; feeds the decoder print input.
REQ-012 SHALL have port valid  output  1  at least one result has been presented since reset; feeds the decoder flag input.

Function
REQ-013 SHALL implement FSM with states IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-014 SHALL accept start only in IDLE: capture bin into a shift register, clear the 12-bit BCD scratch, load iteration counter with W, enter SHIFT.
REQ-015 SHALL ignore start in SHIFT and DONE; no queuing, and the captured operand is unaffected.
REQ-016 SHALL, in SHIFT each cycle: add 3 to every scratch BCD digit >= 5, then shift the {scratch, operand} register left by one bit; decrement the counter.
REQ-017 SHALL leave SHIFT for DONE after exactly W SHIFT cycles.
REQ-018 SHALL, on entering DONE, load hundreds/tens/ones from scratch, assert done for that one cycle, set valid, and return to IDLE next cycle.
REQ-019 SHALL give latency: start accepted at edge N, then done high in cycle N+W+1, with digits valid in the same cycle.
REQ-020 SHALL assert busy in SHIFT and DONE, and deassert it in IDLE.
REQ-021 SHALL hold hundreds/tens/ones and print stable between done pulses, including throughout a subsequent conversion.
REQ-022 SHALL produce exact BCD for all inputs 0..2^W-1; hundreds never exceeds 2.
REQ-023 SHALL keep print = 3'b000 while valid = 0.
REQ-024 SHALL register all outputs, with no combinational path from start or bin to any output.

Reset
REQ-025 SHALL, on reset, set FSM to IDLE, busy=0, done=0, valid=0, hundreds=tens=ones=0, print=000, and clear the scratch, operand and counter.
REQ-026 SHALL abort an in-progress conversion on reset with no done pulse; reset dominates a simultaneous start.
REQ-027 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL support macro LZ_BLANK_EN.
REQ-029 SHALL, with LZ_BLANK_EN defined and valid=1: print[2] = (hundreds!=0), print[1] = (hundreds!=0 or tens!=0), print[0] = 1 (leading-zero blanking; a lone zero is still shown).
REQ-030 SHALL, without LZ_BLANK_EN and with valid=1: print = 3'b111.
REQ-031 SHALL, in both builds, update print in the same cycle as the digits.

Verification
REQ-032 SHALL cover: W=8, reset, bin=255, start at edge 0 -> done only in cycle 9; digits 2,5,5; print=111; busy high cycles 1..9.
REQ-033 SHALL cover: bin=0 -> digits 0,0,0; print=001 with LZ_BLANK_EN, 111 without.
REQ-034 SHALL cover: bin=40 -> digits 0,4,0; print=011 (LZ_BLANK_EN), and bin=7 -> 0,0,7, print=001.
REQ-035 SHALL cover: bin=123 started, start with bin=9 pulsed in cycle 4 -> single done, digits 1,2,3; the second start is ignored.
REQ-036 SHALL cover: bin=200 started, reset in cycle 5 -> no done; all outputs 0, valid=0; the next start with bin=99 yields 0,9,9.
REQ-037 SHALL cover: an exhaustive sweep of 0..255 with back-to-back starts issued the cycle after each done -> every result matches the reference BCD, and previous digits are held during busy.
